xf100_ram_arb: RTL

- Two-requester arbiter and sequencer for the shared single-port 32-bit byte-masked data RAM.
- Requester 0 is the instruction fetch port; requester 1 is the load/store port.
- Grants at most one RAM access per cycle using round-robin, captures read data, and returns it through a one-entry response buffer per requester with valid/ready backpressure.
- Flags out-of-range addresses as errors without touching the RAM.

---
 rtl/xf100_ram_arb_if.sv | 36 +++
 rtl/xf100_ram_arb.sv | 114 +++++++++++
 2 files changed

// File: rtl/xf100_ram_arb_if.sv
// Requester-side command/response bundle for the shared data RAM arbiter.
// Latency: none (signal bundle only).
// Backpressure: req_valid/req_ready on the command, rsp_valid/rsp_ready on the response.
//
// Ports (per requester):
//   req_valid/req_ready  command handshake
//   req_wen, req_mask    1 = write; byte enables, bit i covers bits [8i+7:8i]
//   req_addr, req_wdata  word address and write data
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata, rsp_err   read data (0 for writes/errors); address out of range
interface xf100_ram_arb_if #(
    parameter int AW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic          req_wen;
    logic [3:0]    req_mask;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    // Requester side.
    modport master (
        output req_valid, req_wen, req_mask, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_wen, req_mask, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/xf100_ram_arb.sv
// Round-robin arbiter for the shared single-port byte-masked data RAM (m0 = fetch, m1 = load/store).
// Latency: command to response is 1 cycle; one RAM access per cycle, 1/cycle/requester throughput.
// Backpressure: a requester whose one-entry response buffer is full and not draining is not granted.
//
// Ports: clk, rst (async, active-high); m0/m1 requester bundles (slave side);
//        ram_cs/ram_wen/ram_mask/ram_addr/ram_wdat drive the RAM, ram_rdat is its
//        combinational read data in the same cycle as ram_cs.
module xf100_ram_arb #(
    parameter int AW = 8,
    parameter int DP = 8
) (
    input  logic               clk,
    input  logic               rst,
    xf100_ram_arb_if.slave     m0,
    xf100_ram_arb_if.slave     m1,
    output logic               ram_cs,
    output logic               ram_wen,
    output logic [3:0]         ram_mask,
    output logic [AW-1:0]      ram_addr,
    output logic [31:0]        ram_wdat,
    input  logic [31:0]        ram_rdat
);

    // One extra bit so DP == 2^AW still compares correctly.
    localparam logic [AW:0] DP_W = (AW+1)'(DP);

    logic        last_grant;      // index granted most recently; 1 after reset so m0 wins first tie
    logic        rsp_full0, rsp_full1;
    logic [31:0] rsp_rdata0, rsp_rdata1;
    logic        rsp_err0, rsp_err1;

    logic          elig0, elig1;
    logic          gnt0, gnt1, gnt_any;
    logic          g_wen;
    logic [3:0]    g_mask;
    logic [AW-1:0] g_addr;
    logic [31:0]   g_wdata;
    logic          in_range;
    logic [31:0]   cap_rdata;

    always_comb begin
        // A full response buffer blocks a new grant unless it drains this same cycle.
        // Gating with rst keeps every combinational output low during reset.
        elig0 = ~rst & m0.req_valid & (~rsp_full0 | m0.rsp_ready);
        elig1 = ~rst & m1.req_valid & (~rsp_full1 | m1.rsp_ready);

        gnt0    = elig0 & (~elig1 | last_grant);
        gnt1    = elig1 & (~elig0 | ~last_grant);
        gnt_any = gnt0 | gnt1;

        g_wen   = gnt1 ? m1.req_wen   : m0.req_wen;
        g_mask  = gnt1 ? m1.req_mask  : m0.req_mask;
        g_addr  = gnt1 ? m1.req_addr  : m0.req_addr;
        g_wdata = gnt1 ? m1.req_wdata : m0.req_wdata;

        in_range = {1'b0, g_addr} < DP_W;

        // Out-of-range grants complete with an error but never reach the RAM.
        ram_cs   = gnt_any & in_range;
        ram_wen  = ram_cs ? g_wen   : 1'b0;
        ram_mask = ram_cs ? g_mask  : 4'd0;
        ram_addr = ram_cs ? g_addr  : '0;
        ram_wdat = ram_cs ? g_wdata : 32'd0;

        cap_rdata = (ram_cs & ~g_wen) ? ram_rdat : 32'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (gnt_any) begin
            last_grant <= gnt1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_full0  <= 1'b0;
            rsp_rdata0 <= 32'd0;
            rsp_err0   <= 1'b0;
        end else if (gnt0) begin
            // A new grant overrides a same-cycle drain, keeping the buffer full.
            rsp_full0  <= 1'b1;
            rsp_rdata0 <= cap_rdata;
            rsp_err0   <= ~in_range;
        end else if (m0.rsp_ready) begin
            rsp_full0  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_full1  <= 1'b0;
            rsp_rdata1 <= 32'd0;
            rsp_err1   <= 1'b0;
        end else if (gnt1) begin
            rsp_full1  <= 1'b1;
            rsp_rdata1 <= cap_rdata;
            rsp_err1   <= ~in_range;
        end else if (m1.rsp_ready) begin
            rsp_full1  <= 1'b0;
        end
    end

    assign m0.req_ready = gnt0;
    assign m1.req_ready = gnt1;
    assign m0.rsp_valid = rsp_full0;
    assign m1.rsp_valid = rsp_full1;
    assign m0.rsp_rdata = rsp_rdata0;
    assign m1.rsp_rdata = rsp_rdata1;
    assign m0.rsp_err   = rsp_err0;
    assign m1.rsp_err   = rsp_err1;

endmodule
